mult_div_unit: RTL

//   Multi-cycle multiply/divide unit that sits beside the ALU in the E stage of the pipelined MIPS core.

---
 rtl/mult_div_unit_pkg.sv | 31 +++
 rtl/mult_div_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mult_div_unit_pkg.sv
// ============================================================================
// mult_div_unit_pkg : MDUOp encodings and FSM state type for mult_div_unit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_div_unit_pkg;

    localparam logic [3:0] c_OP_NONE  = 4'd0;
    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == c_OP_MULT) || (op == c_OP_MULTU) ||
               (op == c_OP_DIV)  || (op == c_OP_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit : multi-cycle HI/LO multiply/divide unit for the MIPS E stage
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MDU_A,
    input  logic [31:0] MDU_B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_Out
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    mdu_state_t         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_count, w_count_nxt;
    logic [31:0]        r_hi, r_lo, w_hi_nxt, w_lo_nxt;
    logic [31:0]        r_pend_hi, r_pend_lo, w_pend_hi_nxt, w_pend_lo_nxt;
    logic               r_pend_ok, w_pend_ok_nxt;

    // Results are computed from the operands present at Start and parked until the latency expires.
    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_abs_a, w_abs_b, w_safe_b, w_safe_abs_b;
    logic [31:0] w_uq, w_ur, w_mq, w_mr, w_sq, w_sr;

    assign w_prod_s     = {{32{MDU_A[31]}}, MDU_A} * {{32{MDU_B[31]}}, MDU_B};
    assign w_prod_u     = {32'd0, MDU_A} * {32'd0, MDU_B};
    assign w_abs_a      = MDU_A[31] ? (~MDU_A + 32'd1) : MDU_A;
    assign w_abs_b      = MDU_B[31] ? (~MDU_B + 32'd1) : MDU_B;
    assign w_safe_b     = (MDU_B == 32'd0) ? 32'd1 : MDU_B;
    assign w_safe_abs_b = (MDU_B == 32'd0) ? 32'd1 : w_abs_b;
    assign w_uq         = MDU_A / w_safe_b;
    assign w_ur         = MDU_A % w_safe_b;
    assign w_mq         = w_abs_a / w_safe_abs_b;
    assign w_mr         = w_abs_a % w_safe_abs_b;
    // Magnitude division makes 0x80000000 / -1 wrap to 0x80000000 without special casing.
    assign w_sq         = (MDU_A[31] ^ MDU_B[31]) ? (~w_mq + 32'd1) : w_mq;
    assign w_sr         = MDU_A[31] ? (~w_mr + 32'd1) : w_mr;

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_ok_nxt = r_pend_ok;
        case (r_state)
            S_IDLE: begin
                if (!Req) begin
                    if (Start && is_arith_op(MDUOp)) begin
                        w_state_nxt   = S_RUN;
                        w_pend_ok_nxt = 1'b1;
                        case (MDUOp)
                            c_OP_MULT:  {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_s;
                            c_OP_MULTU: {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_u;
                            c_OP_DIV: begin
                                w_pend_hi_nxt = w_sr;
                                w_pend_lo_nxt = w_sq;
                                w_pend_ok_nxt = (MDU_B != 32'd0);
                            end
                            default: begin
                                w_pend_hi_nxt = w_ur;
                                w_pend_lo_nxt = w_uq;
                                w_pend_ok_nxt = (MDU_B != 32'd0);
                            end
                        endcase
                        if ((MDUOp == c_OP_MULT) || (MDUOp == c_OP_MULTU))
                            w_count_nxt = c_CNT_W'(MULT_CYCLES);
                        else
                            w_count_nxt = c_CNT_W'(DIV_CYCLES);
                    end
                    if (MDUOp == c_OP_MTHI) w_hi_nxt = MDU_A;
                    if (MDUOp == c_OP_MTLO) w_lo_nxt = MDU_A;
                end
            end
            default: begin
                w_count_nxt = r_count - c_CNT_W'(1);
                if (r_count == c_CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    if (r_pend_ok) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_ok <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_ok <= w_pend_ok_nxt;
        end
    end

    assign Busy    = (r_state == S_RUN);
    assign HI      = r_hi;
    assign LO      = r_lo;
    assign MDU_Out = (MDUOp == c_OP_MFHI) ? r_hi :
                     (MDUOp == c_OP_MFLO) ? r_lo : 32'd0;

endmodule

`default_nettype wire
